branch_pred_ctrl: RTL

Sequencing controller for the 2-bit saturating-counter branch prediction datapath in the RISC-V pipeline.
- Owns a PC-indexed table of 2-bit counters and arbitrates its fetch-stage lookup port against its EX-stage update port.
- Tracks in-flight predictions in an ordered queue.
- Compares each resolution against its stored prediction and raises a registered mispredict/flush pulse.

---
 rtl/branch_pred_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl
// Sequencing controller for a 2-bit saturating-counter branch predictor.
// It owns a PC-indexed counter table and arbitrates the fetch-stage lookup
// against the EX-stage update. It keeps in-flight predictions in an ordered
// queue, compares each resolution with its stored prediction, and raises a
// registered mispredict/flush pulse when they differ.
//
// Optional feature macro: BP_BYPASS_EN
//   Defined   : a lookup that hits the index being updated in the same cycle
//               sees the post-update counter value.
//   Undefined : that lookup sees the pre-update value.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   fetch_valid/is_branch/pc fetch-stage instruction presentation
//   fetch_ready              queue not full (from registered count only)
//   pred_valid/pred_taken    registered prediction for last cycle's accept
//   res_valid/res_taken      EX resolution of the oldest in-flight branch
//   mispredict/_taken        registered one-cycle pulse plus actual direction
//   q_count                  in-flight entries, 0..Q_DEPTH
//   err_underflow            sticky: resolution seen with an empty queue
module branch_pred_ctrl #(
  parameter int PC_W    = 32,
  parameter int IDX_W   = 4,
  parameter int Q_DEPTH = 4,
  parameter int Q_AW    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic            fetch_is_branch,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            fetch_ready,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic            res_taken,
  output logic            mispredict,
  output logic            mispredict_taken,
  output logic [Q_AW:0]   q_count,
  output logic            err_underflow
);

  localparam int            TBL_N  = 2 ** IDX_W;
  localparam logic [Q_AW:0] Q_FULL = Q_DEPTH[Q_AW:0];
  localparam logic [Q_AW:0] Q_ZERO = {(Q_AW+1){1'b0}};
  localparam logic [Q_AW:0] Q_ONE  = {{Q_AW{1'b0}}, 1'b1};
  localparam logic [Q_AW-1:0] PTR_ONE = {{(Q_AW-1){1'b0}}, 1'b1};

  // Saturating 2-bit counter step: taken counts up to 11, not-taken down to 00.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr == 2'b11) nxt = 2'b11;
      else              nxt = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) nxt = 2'b00;
      else              nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  logic [1:0]       tbl_q    [TBL_N];
  logic [1:0]       tbl_d    [TBL_N];
  logic [IDX_W-1:0] q_idx_q  [Q_DEPTH];
  logic [IDX_W-1:0] q_idx_d  [Q_DEPTH];
  logic             q_pred_q [Q_DEPTH];
  logic             q_pred_d [Q_DEPTH];
  logic [Q_AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [Q_AW:0]    count_q, count_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic             mispredict_q, mispredict_d;
  logic             mispredict_taken_q, mispredict_taken_d;
  logic             err_underflow_q, err_underflow_d;

  logic             resolve_s, flush_now_s, accept_s, predict_s, head_pred_s;
  logic [IDX_W-1:0] head_idx_s, lkp_idx_s;
  logic [1:0]       upd_ctr_s, lkp_ctr_s;
  logic             pc_unused_s;

  // Only the word-aligned index bits of the PC select a counter.
  assign pc_unused_s = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0]};

  assign fetch_ready      = (count_q != Q_FULL);
  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign mispredict       = mispredict_q;
  assign mispredict_taken = mispredict_taken_q;
  assign q_count          = count_q;
  assign err_underflow    = err_underflow_q;

  // Arbitration: resolve/flush/accept decisions and the table lookup value.
  always_comb begin
    head_idx_s  = q_idx_q[head_q];
    head_pred_s = q_pred_q[head_q];
    resolve_s   = res_valid & (count_q != Q_ZERO);
    flush_now_s = resolve_s & (res_taken != head_pred_s);
    // A mispredict flushes the wrong-path fetch presented in the same cycle.
    accept_s    = fetch_valid & fetch_is_branch & fetch_ready & ~flush_now_s;
    lkp_idx_s   = fetch_pc[IDX_W+1:2];
    upd_ctr_s   = sat_update(tbl_q[head_idx_s], res_taken);
`ifdef BP_BYPASS_EN
    if (resolve_s && (head_idx_s == lkp_idx_s)) lkp_ctr_s = upd_ctr_s;
    else                                        lkp_ctr_s = tbl_q[lkp_idx_s];
`else
    lkp_ctr_s   = tbl_q[lkp_idx_s];
`endif
    predict_s   = lkp_ctr_s[1];
  end

  // Next-state: table write, queue push/pop/flush and registered outputs.
  always_comb begin
    tbl_d    = tbl_q;
    q_idx_d  = q_idx_q;
    q_pred_d = q_pred_q;
    if (resolve_s) tbl_d[head_idx_s] = upd_ctr_s;
    else           tbl_d = tbl_q;
    if (accept_s) begin
      q_idx_d[tail_q]  = lkp_idx_s;
      q_pred_d[tail_q] = predict_s;
    end else begin
      q_idx_d  = q_idx_q;
      q_pred_d = q_pred_q;
    end
    if (flush_now_s) begin
      head_d  = {Q_AW{1'b0}};
      tail_d  = {Q_AW{1'b0}};
      count_d = Q_ZERO;
    end else begin
      head_d = resolve_s ? head_q + PTR_ONE : head_q;
      tail_d = accept_s  ? tail_q + PTR_ONE : tail_q;
      case ({accept_s, resolve_s})
        2'b10:   count_d = count_q + Q_ONE;
        2'b01:   count_d = count_q - Q_ONE;
        default: count_d = count_q;
      endcase
    end
    pred_valid_d       = accept_s;
    pred_taken_d       = accept_s ? predict_s : pred_taken_q;
    mispredict_d       = flush_now_s;
    mispredict_taken_d = resolve_s ? res_taken : mispredict_taken_q;
    err_underflow_d    = err_underflow_q | (res_valid & (count_q == Q_ZERO));
  end

  // State registers; reset restores every counter to weak not-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TBL_N; i++) tbl_q[i] <= 2'b01;
      for (int j = 0; j < Q_DEPTH; j++) begin
        q_idx_q[j]  <= {IDX_W{1'b0}};
        q_pred_q[j] <= 1'b0;
      end
      head_q             <= {Q_AW{1'b0}};
      tail_q             <= {Q_AW{1'b0}};
      count_q            <= Q_ZERO;
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      mispredict_q       <= 1'b0;
      mispredict_taken_q <= 1'b0;
      err_underflow_q    <= 1'b0;
    end else begin
      tbl_q              <= tbl_d;
      q_idx_q            <= q_idx_d;
      q_pred_q           <= q_pred_d;
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      pred_valid_q       <= pred_valid_d;
      pred_taken_q       <= pred_taken_d;
      mispredict_q       <= mispredict_d;
      mispredict_taken_q <= mispredict_taken_d;
      err_underflow_q    <= err_underflow_d;
    end
  end

endmodule
